// File: rtl/seq_det_pkg.sv
// Shared constants for the bit-serial sequence detector: FSM state encodings
// and the default pattern.
package seq_det_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int               DEF_PAT_W   = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_pattern_matcher.sv
// Moore pattern matcher fed one bit per enabled cycle; match is registered.
// SEQDET_OVERLAP_EN defined keeps history after a match (overlapping detection).
module seq_pattern_matcher
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic bit_in,
    output logic match
);

    localparam int             VW     = $clog2(PAT_W + 1);
    localparam logic [VW-1:0] V_FULL = VW'(PAT_W);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [VW-1:0]    vcnt_q, vcnt_d;
    logic [VW-1:0]    vcnt_inc;
    logic             match_q, match_d;

    always_comb begin
        hist_d   = hist_q;
        vcnt_d   = vcnt_q;
        match_d  = 1'b0;
        vcnt_inc = (vcnt_q == V_FULL) ? vcnt_q : vcnt_q + VW'(1);
        if (bit_en) begin
            for (int i = PAT_W - 1; i > 0; i--) begin
                hist_d[i] = hist_q[i-1];
            end
            hist_d[0] = bit_in;
            vcnt_d    = vcnt_inc;
            match_d   = (hist_d == PATTERN) && (vcnt_inc == V_FULL);
`ifdef SEQDET_OVERLAP_EN
`else
            // Non-overlapping: a fresh full pattern must arrive after each hit.
            if (match_d) begin
                vcnt_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= '0;
            vcnt_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            vcnt_q  <= vcnt_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Serialises valid/ready words MSB first into seq_pattern_matcher and counts matches.
// Overlap behaviour of the matcher is selected by SEQDET_OVERLAP_EN.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              clr,
    output logic              busy,
    output logic              match,
    output logic              word_done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat,
    output logic [1:0]        dbg_state
);

    localparam int IW = $clog2(WORD_W);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic              bit_en;
    logic              match_w;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sreg_d    = in_data;
                    bit_idx_d = IW'(WORD_W - 1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sreg_d = sreg_q << 1;
                if (bit_idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    bit_idx_d = bit_idx_q - IW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bit_en = (state_q == ST_SHIFT);

    seq_pattern_matcher #(
        .PAT_W  (PAT_W),
        .PATTERN(PATTERN)
    ) u_matcher (
        .clk   (clk),
        .rst   (rst),
        .bit_en(bit_en),
        .bit_in(sreg_q[WORD_W-1]),
        .match (match_w)
    );

    // clr has priority over a simultaneous match pulse.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (match_w) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_d == '1) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign word_done = (state_q == ST_DONE);
    assign match     = match_w;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;
    assign dbg_state = state_q;

endmodule
